// File: rtl/cp0_ext_pkg.sv
// cp0_ext_pkg: CP0 register numbers, field bit positions, exception codes and EPC helper
package cp0_ext_pkg;
    localparam logic [4:0] CP0_BADVA   = 5'd8;
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;
    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int IM_LO    = 10;
    localparam int CODE_LO  = 2;
    localparam int CAUSE_TI = 30;
    localparam int CAUSE_BD = 31;
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;
    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return (pc & 32'hffff_fffc) - (bd ? 32'd4 : 32'd0);
    endfunction
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare and the sticky timer-interrupt flag TI
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] din,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            count <= count_we ? din : count + 32'd1;
            if (compare_we) compare <= din;
            ti <= compare_we ? 1'b0 : (ti | (count == compare && compare != 32'd0));
        end
    end
endmodule

// File: rtl/cp0_ext.sv
// cp0_ext: M-stage coprocessor 0 (SR, Cause, EPC, BadVAddr, PRId).
// Define CP0_TIMER_EN to build in Count/Compare and the timer interrupt on IP[15].
module cp0_ext
    import cp0_ext_pkg::*;
#(
    parameter int          NUM_HWINT = 6,
    parameter logic [31:0] PRID      = 32'h0000_0001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [4:0]           addr,
    input  logic [31:0]          din,
    output logic [31:0]          dout,
    input  logic [31:0]          vpc,
    input  logic                 bd_in,
    input  logic [4:0]           exc_code_in,
    input  logic [31:0]          bad_vaddr_in,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 exl_clr,
    output logic [31:0]          epc_out,
    output logic                 req,
    output logic                 int_response
);
`ifdef CP0_TIMER_EN
    localparam logic [5:0] TI_BIT = 6'h20;
`else
    localparam logic [5:0] TI_BIT = 6'h00;
`endif
    localparam logic [5:0] IM_MASK = 6'((1 << NUM_HWINT) - 1) | TI_BIT;
    logic [5:0]  im, ip, ip_eff;
    logic        exl, ie, bd, ti, int_pend, exc_pend, wr;
    logic [4:0]  code;
    logic [31:0] epc, bva, count, compare, sr, cause;
    assign ip_eff       = ip | (ti ? 6'h20 : 6'h00);
    assign int_pend     = |(ip_eff & im) & ie & ~exl;
    assign exc_pend     = (exc_code_in != 5'd0) & ~exl;
    assign req          = int_pend | exc_pend;
    assign int_response = int_pend;
    assign wr           = en & ~req;
    assign epc_out      = epc;
`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (wr && addr == CP0_COUNT),
        .compare_we (wr && addr == CP0_COMPARE),
        .din        (din),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            {im, exl, ie, bd, code, ip, epc, bva} <= '0;
        end else begin
            ip <= 6'(hwint);
            if (req) begin
                exl  <= 1'b1;
                bd   <= bd_in;
                code <= int_pend ? 5'd0 : exc_code_in;
                epc  <= epc_of(vpc, bd_in);
                if (!int_pend && (exc_code_in == EXC_ADEL || exc_code_in == EXC_ADES)) bva <= bad_vaddr_in;
            end else begin
                // SR write lands first so a simultaneous eret still clears EXL.
                if (wr && addr == CP0_SR) begin
                    im  <= din[IM_LO +: 6] & IM_MASK;
                    exl <= din[SR_EXL];
                    ie  <= din[SR_IE];
                end
                if (wr && addr == CP0_EPC) epc <= din & 32'hffff_fffc;
                if (exl_clr) exl <= 1'b0;
            end
        end
    end
    always_comb begin
        sr                  = '0;
        sr[IM_LO +: 6]      = im;
        sr[SR_EXL]          = exl;
        sr[SR_IE]           = ie;
        cause               = '0;
        cause[CAUSE_BD]     = bd;
        cause[CAUSE_TI]     = ti;
        cause[IM_LO +: 6]   = ip_eff;
        cause[CODE_LO +: 5] = code;
        case (addr)
            CP0_BADVA:   dout = bva;
            CP0_COUNT:   dout = count;
            CP0_COMPARE: dout = compare;
            CP0_SR:      dout = sr;
            CP0_CAUSE:   dout = cause;
            CP0_EPC:     dout = epc;
            CP0_PRID:    dout = PRID;
            default:     dout = '0;
        endcase
    end
endmodule

// File: tb/tb_cp0_ext.sv
// tb_cp0_ext: directed and random checks of cp0_ext against a behavioural CP0 model
module tb_cp0_ext;
    localparam int NH = 4;
`ifdef CP0_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif
    localparam logic [5:0] MASK = 6'((1 << NH) - 1) | (TMR ? 6'h20 : 6'h00);

    logic clk = 1'b0, reset = 1'b1, en = 1'b0, bd_in = 1'b0, exl_clr = 1'b0;
    logic [4:0] addr = '0, exc_code_in = '0;
    logic [31:0] din = '0, vpc = '0, bad_vaddr_in = '0;
    logic [NH-1:0] hwint = '0;
    logic [31:0] dout, epc_out;
    logic req, int_response;
    int checks = 0, errors = 0;

    logic [5:0] m_im = '0, m_ip = '0;
    logic m_exl = 1'b0, m_ie = 1'b0, m_bd = 1'b0, m_ti = 1'b0;
    logic [4:0] m_code = '0;
    logic [31:0] m_epc = '0, m_bva = '0, m_count = '0, m_cmp = '0;

    cp0_ext #(.NUM_HWINT(NH), .PRID(32'h0000_0001)) dut (
        .clk(clk), .reset(reset), .en(en), .addr(addr), .din(din), .dout(dout),
        .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in), .bad_vaddr_in(bad_vaddr_in),
        .hwint(hwint), .exl_clr(exl_clr), .epc_out(epc_out), .req(req),
        .int_response(int_response)
    );

    always #5 clk = ~clk;

    function automatic logic m_int();
        return ((m_ip | (m_ti ? 6'h20 : 6'h00)) & m_im) != 6'd0 && m_ie && !m_exl;
    endfunction

    function automatic logic m_req();
        return m_int() || (exc_code_in != 5'd0 && !m_exl);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bva;
            5'd9:    return TMR ? m_count : 32'd0;
            5'd11:   return TMR ? m_cmp : 32'd0;
            5'd12:   return (32'(m_im) << 10) + (32'(m_exl) << 1) + 32'(m_ie);
            5'd13:   return (32'(m_bd) << 31) + (32'(m_ti) << 30)
                          + (32'(m_ip | (m_ti ? 6'h20 : 6'h00)) << 10) + (32'(m_code) << 2);
            5'd14:   return m_epc;
            5'd15:   return 32'h1;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step();
        logic r, i, w, nti;
        r = m_req();
        i = m_int();
        w = en && !r;
        nti = TMR && !(w && addr == 5'd11) && (m_ti || (m_count == m_cmp && m_cmp != 0));
        if (r) begin
            m_exl = 1'b1;
            m_bd = bd_in;
            m_code = i ? 5'd0 : exc_code_in;
            m_epc = {vpc[31:2], 2'b00} - (bd_in ? 32'd4 : 32'd0);
            if (!i && (exc_code_in == 5'd4 || exc_code_in == 5'd5)) m_bva = bad_vaddr_in;
        end else begin
            if (w && addr == 5'd12) begin
                m_im = din[15:10] & MASK;
                m_exl = din[1];
                m_ie = din[0];
            end
            if (w && addr == 5'd14) m_epc = {din[31:2], 2'b00};
            if (exl_clr) m_exl = 1'b0;
        end
        if (w && addr == 5'd11) m_cmp = din;
        m_count = (w && addr == 5'd9) ? din : m_count + 32'd1;
        m_ti = nti;
        m_ip = 6'(hwint);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        #1;
        chk("req", 32'(req), 32'(m_req()));
        chk("int_response", 32'(int_response), 32'(m_int()));
        chk("epc_out", epc_out, m_epc);
        chk("dout", dout, m_read(addr));
        m_step();
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [4:0] picks [8];
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        foreach (picks[k]) picks[k] = 5'd0;
        // reset state
        addr = 5'd8;  #1 chk("rst_badva", dout, 32'd0);
        addr = 5'd15; #1 chk("rst_prid", dout, 32'h1);
        addr = 5'd12; #1 chk("rst_sr", dout, 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        cyc();
        addr = 5'd13; cyc();
        addr = 5'd14; cyc();
        // interrupt on hwint[0]
        en = 1'b1; addr = 5'd12; din = 32'h0000_0401; cyc();
        en = 1'b0; hwint = 4'h1; vpc = 32'h3010; cyc();
        addr = 5'd13;
        #1 chk("irq_req", {30'd0, req, int_response}, 32'd3);
        cyc();
        hwint = 4'h0; addr = 5'd12;
        #1 chk("irq_sr", dout, 32'h0000_0403);
        addr = 5'd13;
        #1 chk("irq_cause", dout, 32'h0000_0400);
        chk("irq_epc", epc_out, 32'h3010);
        cyc();
        exl_clr = 1'b1; cyc();
        exl_clr = 1'b0;
        // AdES in a delay slot
        exc_code_in = 5'd5; bd_in = 1'b1; vpc = 32'h3024; bad_vaddr_in = 32'h7f22;
        #1 chk("ades_req", {30'd0, req, int_response}, 32'd2);
        cyc();
        exc_code_in = 5'd0; bd_in = 1'b0;
        chk("ades_epc", epc_out, 32'h3020);
        addr = 5'd13; #1 chk("ades_cause", dout, 32'h8000_0014);
        addr = 5'd8;  #1 chk("ades_badva", dout, 32'h7f22);
        cyc();
        // EXL masks exceptions until eret
        exc_code_in = 5'd10;
        #1 chk("exl_mask", 32'(req), 32'd0);
        cyc();
        exl_clr = 1'b1; cyc();
        exl_clr = 1'b0;
        #1 chk("after_eret", 32'(req), 32'd1);
        cyc();
        exc_code_in = 5'd0;
        exl_clr = 1'b1; cyc();
        exl_clr = 1'b0; hwint = 4'h1; cyc();
        // EPC write collides with an interrupt and is dropped
        vpc = 32'h3040; en = 1'b1; addr = 5'd14; din = 32'h3047;
        #1 chk("collide_req", 32'(req), 32'd1);
        cyc();
        en = 1'b0; hwint = 4'h0;
        chk("collide_epc", epc_out, 32'h3040);
        cyc();
        exl_clr = 1'b1; cyc();
        exl_clr = 1'b0; en = 1'b1; addr = 5'd14; din = 32'h3047;
        #1 chk("epcw_noreq", 32'(req), 32'd0);
        cyc();
        en = 1'b0;
        chk("epcw_val", epc_out, 32'h3044);
        cyc();
        if (TMR) begin
            en = 1'b1; addr = 5'd11; din = 32'd5; cyc();
            addr = 5'd9; din = 32'd0; cyc();
            addr = 5'd12; din = 32'h0000_8001; cyc();
            en = 1'b0; addr = 5'd13; n = 0;
            while (!req && n < 20) begin
                cyc();
                n++;
            end
            #1 chk("timer_req", 32'(req), 32'd1);
            chk("timer_ti", 32'(dout[30]), 32'd1);
            cyc();
            en = 1'b1; addr = 5'd11; din = 32'd0; cyc();
            en = 1'b0; addr = 5'd13;
            #1 chk("timer_ti_clr", 32'(dout[30]), 32'd0);
            exl_clr = 1'b1; cyc();
            exl_clr = 1'b0;
        end
        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            picks[0] = 5'd8;  picks[1] = 5'd9;  picks[2] = 5'd11; picks[3] = 5'd12;
            picks[4] = 5'd13; picks[5] = 5'd14; picks[6] = 5'd15; picks[7] = 5'($urandom);
            addr = picks[$urandom_range(0, 7)];
            en = ($urandom_range(0, 2) == 0);
            din = $urandom;
            vpc = $urandom;
            bd_in = 1'($urandom);
            bad_vaddr_in = $urandom;
            exc_code_in = ($urandom_range(0, 6) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            hwint = ($urandom_range(0, 3) == 0) ? NH'($urandom) : '0;
            exl_clr = ($urandom_range(0, 4) == 0);
            cyc();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
